mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Command-to-RAM access controller: valid/ready command in, single-beat
// RAM strobe, registered response held until the upstream consumes it.
module mem_access_ctrl #(
    parameter int DEPTH = 32,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [7:0]    cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [7:0]    rsp_data,
    output logic          rsp_error,
    output logic          request_ram,
    output logic          mem_control,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_data_in,
    input  logic [7:0]    mem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // one extra bit so DEPTH == 2**AW still compares correctly
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    state_t        r_state;
    state_t        w_next;
    logic          r_write;
    logic          r_request_ram;
    logic          r_mem_control;
    logic [AW-1:0] r_mem_addr;
    logic [7:0]    r_mem_data_in;
    logic          r_rsp_valid;
    logic [7:0]    r_rsp_data;
    logic          r_rsp_error;

    logic          w_write;
    logic          w_request_ram;
    logic          w_mem_control;
    logic [AW-1:0] w_mem_addr;
    logic [7:0]    w_mem_data_in;
    logic          w_rsp_valid;
    logic [7:0]    w_rsp_data;
    logic          w_rsp_error;
    logic          w_in_range;

    assign w_in_range = ({1'b0, cmd_addr} < LP_DEPTH);

    assign cmd_ready   = (r_state == S_IDLE) && !rst;
    assign request_ram = r_request_ram;
    assign mem_control = r_mem_control;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data_in;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_error   = r_rsp_error;

    always_comb begin
        w_next        = r_state;
        w_write       = r_write;
        w_request_ram = 1'b0;
        w_mem_control = 1'b0;
        w_mem_addr    = r_mem_addr;
        w_mem_data_in = r_mem_data_in;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_data    = r_rsp_data;
        w_rsp_error   = r_rsp_error;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_write = cmd_write;
                    if (w_in_range) begin
                        w_next        = S_ISSUE;
                        w_request_ram = 1'b1;
                        w_mem_control = ~cmd_write;
                        w_mem_addr    = cmd_addr;
                        w_mem_data_in = cmd_wdata;
                    end else begin
                        w_next      = S_RESP;
                        w_rsp_valid = 1'b1;
                        w_rsp_data  = 8'h00;
                        w_rsp_error = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (r_write) begin
                    w_next      = S_RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = 8'h00;
                    w_rsp_error = 1'b0;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // RAM read data is valid during this cycle only
                w_next      = S_RESP;
                w_rsp_valid = 1'b1;
                w_rsp_data  = mem_data_out;
                w_rsp_error = 1'b0;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next      = S_IDLE;
                    w_rsp_valid = 1'b0;
                    w_rsp_data  = 8'h00;
                    w_rsp_error = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_write       <= 1'b0;
            r_request_ram <= 1'b0;
            r_mem_control <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data_in <= 8'h00;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= 8'h00;
            r_rsp_error   <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_write       <= w_write;
            r_request_ram <= w_request_ram;
            r_mem_control <= w_mem_control;
            r_mem_addr    <= w_mem_addr;
            r_mem_data_in <= w_mem_data_in;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_data    <= w_rsp_data;
            r_rsp_error   <= w_rsp_error;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small behavioural RAM whose
// initial contents are 0x40 + address.
module tb_mem_access_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [7:0]    rsp_data;
    logic          rsp_error;
    logic          request_ram;
    logic          mem_control;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data_in;
    logic [7:0]    mem_data_out = 8'h00;

    logic [7:0]    ram [DEPTH];
    logic          ram_init;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_strobe = 0;
    int            strobe_base;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_error   (rsp_error),
        .request_ram (request_ram),
        .mem_control (mem_control),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out)
    );

    // RAM: write on strobe, read data presented for one cycle after strobe
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 8'h40 + 8'(i);
            mem_data_out <= 8'h00;
        end else begin
            if (request_ram && !mem_control)
                ram[mem_addr[4:0]] <= mem_data_in;
            if (request_ram && mem_control)
                mem_data_out <= ram[mem_addr[4:0]];
            else
                mem_data_out <= 8'h00;
        end
    end

    always @(negedge clk) if (request_ram) n_strobe++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, " request_ram"}, 32'(request_ram), 0);
        chk({tag, " mem_control"}, 32'(mem_control), 0);
        chk({tag, " mem_addr"},    32'(mem_addr), 0);
        chk({tag, " mem_data_in"}, 32'(mem_data_in), 0);
        chk({tag, " rsp_valid"},   32'(rsp_valid), 0);
        chk({tag, " rsp_data"},    32'(rsp_data), 0);
        chk({tag, " rsp_error"},   32'(rsp_error), 0);
        chk({tag, " cmd_ready"},   32'(cmd_ready), 0);
    endtask

    task automatic cmd(input logic wr, input logic [AW-1:0] a,
                       input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        rst       = 1'b1;
        ram_init  = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b0;
        tick();
        tick();
        outs_zero("reset");

        // first command accepted on the first edge after reset release
        rst      = 1'b0;
        ram_init = 1'b0;
        #1;
        chk("ready after rst", 32'(cmd_ready), 1);
        cmd(1'b1, 12'd5, 8'hA5);
        tick();
        chk("wr strobe",   32'(request_ram), 1);
        chk("wr ctrl",     32'(mem_control), 0);
        chk("wr addr",     32'(mem_addr), 5);
        chk("wr din",      32'(mem_data_in), 32'hA5);
        chk("wr busy",     32'(cmd_ready), 0);
        chk("wr lat1",     32'(rsp_valid), 0);
        cmd_valid = 1'b0;
        tick();
        chk("wr strobe off", 32'(request_ram), 0);
        chk("wr lat2",     32'(rsp_valid), 1);
        chk("wr data",     32'(rsp_data), 0);
        chk("wr err",      32'(rsp_error), 0);
        chk("addr hold",   32'(mem_addr), 5);
        rsp_ready = 1'b1;
        tick();
        chk("wr done",     32'(rsp_valid), 0);
        chk("wr idle",     32'(cmd_ready), 1);

        // read back address 5
        cmd(1'b0, 12'd5, 8'h00);
        tick();
        chk("rd strobe",   32'(request_ram), 1);
        chk("rd ctrl",     32'(mem_control), 1);
        cmd_valid = 1'b0;
        tick();
        chk("rd ctrl off", 32'(mem_control), 0);
        chk("rd lat2",     32'(rsp_valid), 0);
        tick();
        chk("rd lat3",     32'(rsp_valid), 1);
        chk("rd data",     32'(rsp_data), 32'hA5);
        chk("rd err",      32'(rsp_error), 0);
        tick();
        chk("rd done",     32'(rsp_valid), 0);
        chk("rd data clr", 32'(rsp_data), 0);
        chk("strobes 2",   32'(n_strobe), 2);

        // out of range: DEPTH and a value that aliases 5 if truncated
        cmd(1'b0, 12'd32, 8'h00);
        tick();
        chk("err valid",   32'(rsp_valid), 1);
        chk("err flag",    32'(rsp_error), 1);
        chk("err data",    32'(rsp_data), 0);
        chk("err nostrb",  32'(request_ram), 0);
        cmd(1'b1, 12'h805, 8'h11);
        tick();
        chk("err1 done",   32'(rsp_valid), 0);
        tick();
        chk("err hi flag", 32'(rsp_error), 1);
        chk("err hi addr", 32'(mem_addr), 5);
        cmd_valid = 1'b0;
        tick();
        chk("strobes err", 32'(n_strobe), 2);

        // DEPTH-1 is legal
        cmd(1'b0, 12'd31, 8'h00);
        tick();
        chk("a31 strobe",  32'(request_ram), 1);
        chk("a31 addr",    32'(mem_addr), 31);
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("a31 data",    32'(rsp_data), 32'h5F);
        chk("a31 err",     32'(rsp_error), 0);
        tick();

        // response back-pressure
        rsp_ready = 1'b0;
        cmd(1'b0, 12'd2, 8'h00);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp valid", 32'(rsp_valid), 1);
            chk("bp data",  32'(rsp_data), 32'h42);
            chk("bp ready", 32'(cmd_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp release",  32'(rsp_valid), 0);
        chk("bp idle",     32'(cmd_ready), 1);

        // back-to-back reads, cmd_valid held throughout
        strobe_base = n_strobe;
        cmd(1'b0, 12'd0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("b2b strobe", 32'(request_ram), 1);
            chk("b2b addr",   32'(mem_addr), 32'(k));
            tick();
            chk("b2b busy",   32'(cmd_ready), 0);
            tick();
            chk("b2b valid",  32'(rsp_valid), 1);
            chk("b2b data",   32'(rsp_data), 32'h40 + 32'(k));
            tick();
            chk("b2b idle",   32'(cmd_ready), 1);
            cmd_addr = AW'(k + 1);
        end
        cmd_valid = 1'b0;
        tick();
        chk("b2b strobes", 32'(n_strobe - strobe_base), 4);

        // reset during WAIT aborts the read
        cmd(1'b0, 12'd3, 8'h00);
        tick();
        cmd_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        outs_zero("rst wait");
        tick();
        chk("abort novalid", 32'(rsp_valid), 0);
        rst = 1'b0;
        tick();
        chk("abort novalid2", 32'(rsp_valid), 0);
        chk("abort idle",  32'(cmd_ready), 1);
        cmd(1'b0, 12'd4, 8'h00);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("post rst data", 32'(rsp_data), 32'h44);
        tick();

        // write dropped by reset before its ISSUE edge
        cmd(1'b1, 12'd7, 8'h99);
        tick();
        chk("w7 strobe",   32'(request_ram), 1);
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("w7 killed",   32'(request_ram), 0);
        tick();
        rst = 1'b0;
        tick();
        cmd(1'b0, 12'd7, 8'h00);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("w7 unchanged", 32'(rsp_data), 32'h47);
        tick();
        chk("strobe total", 32'(n_strobe), 11);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
